product_accumulator: RTL and testbench

Signed multiply-accumulate back end that sits directly downstream of the Booth multiplier stage. It accepts a stream of signed products over a valid/ready handshake and sums them into a saturating accumulator. After `LEN` terms, or earlier on an explicit `in_last`, it presents the block sum, term count and a sticky saturation flag on a valid/ready output port. It then clears itself for the next block.

---
 rtl/product_accumulator_if.sv | 26 ++
 rtl/product_accumulator.sv | 90 +++++++++
 tb/tb_product_accumulator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Valid/ready term input and result output of the product accumulator,
// bundled so the multiplier side and the consumer side share one port.
interface product_accumulator_if #(
  parameter int PW = 16,
  parameter int AW = 20
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_product;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_sum;
  logic [7:0]           out_count;
  logic                 out_sat;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/product_accumulator.sv
// Saturating signed accumulator for Booth multiplier products. It sums LEN terms,
// or fewer when in_last closes the block, then holds the result until it is taken.
module product_accumulator #(
  parameter int PW  = 16,
  parameter int AW  = 20,
  parameter int LEN = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t               state_reg;
  logic signed [AW-1:0] acc_reg;
  logic [7:0]           count_reg;
  logic                 sat_reg;

  logic signed [AW:0]   acc_ext;
  logic signed [AW:0]   prod_ext;
  logic signed [AW:0]   sum_wide;
  logic signed [AW-1:0] acc_next;
  logic                 sat_now;
  logic [7:0]           count_next;
  logic                 accept;

  localparam logic signed [AW:0]   SUM_MAX = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0]   SUM_MIN = {2'b11, {(AW-1){1'b0}}};
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [7:0]           LEN_C   = 8'(LEN);

  // Handshake flags depend only on state and reset, never on the peer's signals.
  assign bus.in_ready  = rst_n && (state_reg == ACC);
  assign bus.out_valid = rst_n && (state_reg == HOLD);
  assign bus.out_sum   = acc_reg;
  assign bus.out_count = count_reg;
  assign bus.out_sat   = sat_reg;

  assign accept     = bus.in_valid && bus.in_ready;
  assign acc_ext    = {acc_reg[AW-1], acc_reg};
  assign prod_ext   = {{(AW+1-PW){bus.in_product[PW-1]}}, bus.in_product};
  assign sum_wide   = acc_ext + prod_ext;
  assign count_next = count_reg + 8'd1;

  // One extra bit of headroom makes overflow visible before it is clamped.
  always_comb begin
    acc_next = sum_wide[AW-1:0];
    sat_now  = 1'b0;
    if (sum_wide > SUM_MAX) begin
      acc_next = ACC_MAX;
      sat_now  = 1'b1;
    end else if (sum_wide < SUM_MIN) begin
      acc_next = ACC_MIN;
      sat_now  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ACC: begin
          if (accept) begin
            acc_reg   <= acc_next;
            count_reg <= count_next;
            sat_reg   <= sat_reg | sat_now;
            if (count_next == LEN_C || bus.in_last)
              state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
            state_reg <= ACC;
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: one LEN=4 instance for block/backpressure/reset cases and one
// LEN=32 instance for the saturation cases; values are hand-computed.
module tb_product_accumulator;

  localparam int PW = 16;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PW(PW), .AW(AW)) a_if ();
  product_accumulator_if #(.PW(PW), .AW(AW)) b_if ();

  product_accumulator #(.PW(PW), .AW(AW), .LEN(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  product_accumulator #(.PW(PW), .AW(AW), .LEN(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Present one term (sel 0 = LEN 4 instance, 1 = LEN 32 instance) for one edge.
  task automatic push(input bit sel, input int p, input bit last);
    if (!sel) begin
      a_if.in_valid = 1'b1; a_if.in_product = PW'(p); a_if.in_last = last;
    end else begin
      b_if.in_valid = 1'b1; b_if.in_product = PW'(p); b_if.in_last = last;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_last = 1'b0;
  endtask

  task automatic check_a(input string tag, input int v, input int sum, input int cnt, input int sat);
    check({tag, ".valid"}, int'(a_if.out_valid), v);
    check({tag, ".sum"},   int'(a_if.out_sum),   sum);
    check({tag, ".count"}, int'(a_if.out_count), cnt);
    check({tag, ".sat"},   int'(a_if.out_sat),   sat);
  endtask

  task automatic check_b(input string tag, input int v, input int sum, input int cnt, input int sat);
    check({tag, ".valid"}, int'(b_if.out_valid), v);
    check({tag, ".sum"},   int'(b_if.out_sum),   sum);
    check({tag, ".count"}, int'(b_if.out_count), cnt);
    check({tag, ".sat"},   int'(b_if.out_sat),   sat);
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_product = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_product = '0; b_if.in_last = 1'b0; b_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.in_ready", int'(a_if.in_ready), 0);
    check("rst.out_valid", int'(a_if.out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready_after", int'(a_if.in_ready), 1);
    check_a("rst", 0, 0, 0, 0);

    // Basic block: 100-50+25+7 = 82, valid for exactly one cycle
    push(0, 100, 0); push(0, -50, 0); push(0, 25, 0);
    check("basic.no_early_valid", int'(a_if.out_valid), 0);
    check("basic.partial_count", int'(a_if.out_count), 3);
    push(0, 7, 0);
    idle();
    check_a("basic", 1, 82, 4, 0);
    check("basic.in_ready_hold", int'(a_if.in_ready), 0);
    @(negedge clk);
    check("basic.valid_one_cycle", int'(a_if.out_valid), 0);
    check("basic.in_ready_back", int'(a_if.in_ready), 1);
    check("basic.cleared_count", int'(a_if.out_count), 0);

    // Backpressure: result held while product 9 waits
    a_if.out_ready = 1'b0;
    push(0, 1, 0); push(0, 2, 0); push(0, 3, 0); push(0, 4, 0);
    a_if.in_valid = 1'b1; a_if.in_product = 16'sd9; a_if.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_a($sformatf("bp.hold%0d", i), 1, 10, 4, 0);
      check($sformatf("bp.in_ready%0d", i), int'(a_if.in_ready), 0);
      @(negedge clk);
    end
    a_if.out_ready = 1'b1;
    @(negedge clk);
    check_a("bp.handshake", 0, 0, 0, 0);
    check("bp.in_ready_after", int'(a_if.in_ready), 1);
    @(negedge clk);
    check_a("bp.took9", 0, 9, 1, 0);
    push(0, 0, 1);
    idle();
    check_a("bp.block", 1, 9, 2, 0);
    @(negedge clk);

    // Early close on the first term
    push(0, -5, 1);
    idle();
    check_a("early", 1, -5, 1, 0);
    @(negedge clk);

    // in_last without valid must not close a block
    a_if.in_last = 1'b1;
    @(negedge clk);
    a_if.in_last = 1'b0;
    check("lastnovalid.valid", int'(a_if.out_valid), 0);

    // Reset mid-block discards the partial sum
    push(0, 10, 0); push(0, 20, 0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.in_ready", int'(a_if.in_ready), 0);
    check("midrst.out_valid", int'(a_if.out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_a("midrst.cleared", 0, 0, 0, 0);
    push(0, 1, 0); push(0, 1, 0); push(0, 1, 0); push(0, 1, 0);
    idle();
    check_a("midrst.block", 1, 4, 4, 0);
    @(negedge clk);
    check("midrst.single", int'(a_if.out_valid), 0);

    // Positive saturation (LEN 32): 16*32767 fits, 17th term clamps
    for (int i = 0; i < 16; i++) push(1, 32767, 0);
    check_b("pos.16", 0, 524272, 16, 0);
    push(1, 32767, 0);
    check_b("pos.17", 0, 524287, 17, 1);
    push(1, 32767, 0); push(1, 32767, 0); push(1, 32767, 1);
    idle();
    check_b("pos.block", 1, 524287, 20, 1);
    @(negedge clk);

    // Negative saturation: exactly -2^19 does not saturate, the 17th term does
    for (int i = 0; i < 16; i++) push(1, -32768, 0);
    check_b("neg.16", 0, -524288, 16, 0);
    push(1, -32768, 0);
    check_b("neg.17", 0, -524288, 17, 1);
    push(1, 32767, 1);
    idle();
    check_b("neg.block", 1, -491521, 18, 1);
    @(negedge clk);

    // Recovery: sat flag does not leak into the next block
    push(1, 1, 0); push(1, 2, 0); push(1, 3, 0); push(1, 4, 1);
    idle();
    check_b("recover", 1, 10, 4, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
